// File: rtl/run_sequencer.sv
// Run controller in front of the processor core: loads operands into data memory,
// runs the core under a timeout guard, then streams a result window back out.
module run_sequencer #(
    parameter int AW        = 8,
    parameter int LOAD_BASE = 0,
    parameter int LOAD_LEN  = 64,
    parameter int DUMP_BASE = 64,
    parameter int DUMP_LEN  = 64,
    parameter int TIMEOUT   = 4096,
    parameter int CW        = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          in_valid,
    input  logic [7:0]    in_data,
    output logic          in_ready,
    output logic          core_reset,
    input  logic          core_done,
    output logic          mem_sel,
    output logic          mem_wr_en,
    output logic [AW-1:0] mem_addr,
    output logic [7:0]    mem_wdat,
    input  logic [7:0]    mem_rdat,
    output logic          out_valid,
    output logic [7:0]    out_data,
    output logic          out_last,
    input  logic          out_ready,
    output logic          busy,
    output logic          timeout_err,
    output logic [CW-1:0] cycle_count
);

    // Streams on both sides move a byte only on a cycle where valid and ready are both high.
    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_BOOT,
        S_RUN,
        S_DUMP
    } state_t;

    state_t        state_q, state_d;
    logic [31:0]   idx_q, idx_d;
    logic [CW-1:0] cycle_count_q, cycle_count_d;
    logic          timeout_err_q, timeout_err_d;
    logic          dump_last;

    assign busy        = (state_q != S_IDLE);
    assign timeout_err = timeout_err_q;
    assign cycle_count = cycle_count_q;
    assign dump_last   = (idx_q == 32'(DUMP_LEN - 1));

    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        cycle_count_d = cycle_count_q;
        timeout_err_d = timeout_err_q;
        in_ready      = 1'b0;
        core_reset    = 1'b1;
        mem_sel       = 1'b1;
        mem_wr_en     = 1'b0;
        mem_addr      = '0;
        mem_wdat      = in_data;
        out_valid     = 1'b0;
        out_data      = '0;
        out_last      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    cycle_count_d = '0;
                    timeout_err_d = 1'b0;
                    idx_d         = '0;
                    state_d       = (LOAD_LEN > 0) ? S_LOAD : S_BOOT;
                end
            end
            S_LOAD: begin
                in_ready  = 1'b1;
                mem_addr  = AW'(LOAD_BASE + idx_q);
                mem_wr_en = in_valid;
                if (in_valid) begin
                    if (idx_q == 32'(LOAD_LEN - 1)) begin
                        idx_d   = '0;
                        state_d = S_BOOT;
                    end else begin
                        idx_d = idx_q + 32'd1;
                    end
                end
            end
            S_BOOT: begin
                // Memory is handed back one cycle before the core leaves reset.
                mem_sel = 1'b0;
                state_d = S_RUN;
            end
            S_RUN: begin
                core_reset = 1'b0;
                mem_sel    = 1'b0;
                if (cycle_count_q != '1) begin
                    cycle_count_d = cycle_count_q + 1'b1;
                end
                // A done flag on the final allowed cycle still counts as a clean finish.
                if (core_done) begin
                    idx_d   = '0;
                    state_d = (DUMP_LEN > 0) ? S_DUMP : S_IDLE;
                end else if (cycle_count_q == CW'(TIMEOUT - 1)) begin
                    timeout_err_d = 1'b1;
                    idx_d         = '0;
                    state_d       = (DUMP_LEN > 0) ? S_DUMP : S_IDLE;
                end
            end
            S_DUMP: begin
                mem_addr  = AW'(DUMP_BASE + idx_q);
                out_valid = 1'b1;
                out_data  = mem_rdat;
                out_last  = dump_last;
                if (out_ready) begin
                    if (dump_last) begin
                        idx_d   = '0;
                        state_d = S_IDLE;
                    end else begin
                        idx_d = idx_q + 32'd1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_IDLE;
            idx_q         <= '0;
            cycle_count_q <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            cycle_count_q <= cycle_count_d;
            timeout_err_q <= timeout_err_d;
        end
    end

endmodule

// File: tb/tb_run_sequencer.sv
// Directed bench for run_sequencer: default instance with a memory model, plus
// two small instances covering address wrap and zero-length load/dump.
module tb_run_sequencer;

  logic clk = 1'b0;
  logic reset;
  int checks = 0;
  int failures = 0;
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  // Default instance
  logic a_start, a_in_valid, a_in_ready, a_core_reset, a_core_done, a_mem_sel, a_mem_wr_en;
  logic [7:0] a_in_data, a_mem_addr, a_mem_wdat, a_mem_rdat, a_out_data;
  logic a_out_valid, a_out_last, a_out_ready, a_busy, a_timeout_err;
  logic [15:0] a_cycle_count;

  run_sequencer dut_a (
    .clk(clk), .reset(reset), .start(a_start), .in_valid(a_in_valid), .in_data(a_in_data),
    .in_ready(a_in_ready), .core_reset(a_core_reset), .core_done(a_core_done),
    .mem_sel(a_mem_sel), .mem_wr_en(a_mem_wr_en), .mem_addr(a_mem_addr), .mem_wdat(a_mem_wdat),
    .mem_rdat(a_mem_rdat), .out_valid(a_out_valid), .out_data(a_out_data), .out_last(a_out_last),
    .out_ready(a_out_ready), .busy(a_busy), .timeout_err(a_timeout_err), .cycle_count(a_cycle_count)
  );

  // Wrapping load, no dump
  logic b_start, b_in_valid, b_in_ready, b_core_reset, b_core_done, b_mem_sel, b_mem_wr_en;
  logic [7:0] b_in_data, b_mem_addr, b_mem_wdat, b_out_data;
  logic b_out_valid, b_out_last, b_busy, b_timeout_err;
  logic [15:0] b_cycle_count;

  run_sequencer #(.LOAD_BASE(250), .LOAD_LEN(10), .DUMP_LEN(0)) dut_b (
    .clk(clk), .reset(reset), .start(b_start), .in_valid(b_in_valid), .in_data(b_in_data),
    .in_ready(b_in_ready), .core_reset(b_core_reset), .core_done(b_core_done),
    .mem_sel(b_mem_sel), .mem_wr_en(b_mem_wr_en), .mem_addr(b_mem_addr), .mem_wdat(b_mem_wdat),
    .mem_rdat(8'h00), .out_valid(b_out_valid), .out_data(b_out_data), .out_last(b_out_last),
    .out_ready(1'b1), .busy(b_busy), .timeout_err(b_timeout_err), .cycle_count(b_cycle_count)
  );

  // No load, short timeout, wrapping dump
  logic c_start, c_in_ready, c_core_reset, c_mem_sel, c_mem_wr_en;
  logic [7:0] c_mem_addr, c_mem_wdat, c_mem_rdat, c_out_data;
  logic c_out_valid, c_out_last, c_out_ready, c_busy, c_timeout_err;
  logic [15:0] c_cycle_count;

  run_sequencer #(.LOAD_LEN(0), .DUMP_BASE(254), .DUMP_LEN(4), .TIMEOUT(8)) dut_c (
    .clk(clk), .reset(reset), .start(c_start), .in_valid(1'b0), .in_data(8'h00),
    .in_ready(c_in_ready), .core_reset(c_core_reset), .core_done(1'b0),
    .mem_sel(c_mem_sel), .mem_wr_en(c_mem_wr_en), .mem_addr(c_mem_addr), .mem_wdat(c_mem_wdat),
    .mem_rdat(c_mem_rdat), .out_valid(c_out_valid), .out_data(c_out_data), .out_last(c_out_last),
    .out_ready(c_out_ready), .busy(c_busy), .timeout_err(c_timeout_err), .cycle_count(c_cycle_count)
  );

  assign c_mem_rdat = c_mem_addr ^ 8'h3C;

  // Data memory model for the default instance
  logic [7:0] mem [256];
  int wr_cnt = 0;
  int out_cnt = 0;
  int b_ov_cnt = 0;

  assign a_mem_rdat = mem[a_mem_addr];

  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 256; i++) mem[i] <= 8'(i) ^ 8'hA5;
    end else if (a_mem_sel && a_mem_wr_en) begin
      mem[a_mem_addr] <= a_mem_wdat;
      wr_cnt <= wr_cnt + 1;
    end
  end

  always @(posedge clk) begin
    if (a_out_valid && a_out_ready) out_cnt <= out_cnt + 1;
    if (b_out_valid) b_ov_cnt <= b_ov_cnt + 1;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic begin_run();
    a_start = 1'b1;
    cyc();
    a_start = 1'b0;
    #1;
    chk("start_busy", a_busy, 1);
    chk("start_in_ready", a_in_ready, 1);
    chk("start_cc_clear", a_cycle_count, 0);
    chk("start_te_clear", a_timeout_err, 0);
  endtask

  task automatic load_bytes(input logic [7:0] base_val, input bit gaps);
    for (int b = 0; b < 64; b++) begin
      if (gaps && (b % 3 == 1)) begin
        a_in_valid = 1'b0;
        #1;
        chk("load_gap_wr", a_mem_wr_en, 0);
        chk("load_gap_ready", a_in_ready, 1);
        cyc();
      end
      a_in_valid = 1'b1;
      a_in_data = base_val + 8'(b);
      #1;
      chk("load_wr", a_mem_wr_en, 1);
      chk("load_addr", a_mem_addr, b);
      chk("load_core_reset", a_core_reset, 1);
      cyc();
    end
    a_in_valid = 1'b0;
  endtask

  task automatic boot_run(input int done_at, input int n);
    #1;
    chk("boot_core_reset", a_core_reset, 1);
    chk("boot_mem_sel", a_mem_sel, 0);
    chk("boot_in_ready", a_in_ready, 0);
    cyc();
    for (int k = 1; k <= n; k++) begin
      a_core_done = (k == done_at);
      #1;
      if (k == 1) begin
        chk("run_core_reset", a_core_reset, 0);
        chk("run_mem_sel", a_mem_sel, 0);
      end
      if (k == n) begin
        chk("run_last_cc", a_cycle_count, n - 1);
        chk("run_last_te", a_timeout_err, 0);
      end
      cyc();
    end
    a_core_done = 1'b0;
  endtask

  task automatic dump_all(input int stall_at, input int stall_len);
    for (int a = 0; a < 64; a++) exp_q.push_back(8'(64 + a) ^ 8'hA5);
    for (int j = 0; j < 64; j++) begin
      if (j == stall_at) begin
        a_out_ready = 1'b0;
        for (int s = 0; s < stall_len; s++) begin
          #1;
          chk("stall_valid", a_out_valid, 1);
          chk("stall_data", a_out_data, exp_q[0]);
          chk("stall_last", a_out_last, 0);
          cyc();
        end
      end
      a_out_ready = 1'b1;
      #1;
      chk("dump_valid", a_out_valid, 1);
      chk("dump_data", a_out_data, exp_q[0]);
      chk("dump_last", a_out_last, exp_q.size() == 1);
      chk("dump_core_reset", a_core_reset, 1);
      void'(exp_q.pop_front());
      cyc();
    end
    a_out_ready = 1'b0;
    #1;
    chk("dump_end_busy", a_busy, 0);
    chk("dump_end_valid", a_out_valid, 0);
  endtask

  initial begin
    int snap;
    int bad;
    reset = 1'b1;
    a_start = 0; a_in_valid = 0; a_in_data = 0; a_core_done = 0; a_out_ready = 0;
    b_start = 0; b_in_valid = 0; b_in_data = 0; b_core_done = 0;
    c_start = 0; c_out_ready = 0;
    cyc();
    cyc();
    reset = 1'b0;
    #1;
    chk("rst_busy", a_busy, 0);
    chk("rst_core_reset", a_core_reset, 1);
    chk("rst_mem_sel", a_mem_sel, 1);
    chk("rst_wr_en", a_mem_wr_en, 0);
    chk("rst_in_ready", a_in_ready, 0);
    chk("rst_out_valid", a_out_valid, 0);
    chk("rst_out_last", a_out_last, 0);
    chk("rst_te", a_timeout_err, 0);
    chk("rst_cc", a_cycle_count, 0);
    cyc();

    // Nominal run
    snap = wr_cnt;
    begin_run();
    load_bytes(8'h00, 1'b0);
    chk("nom_wr_count", wr_cnt - snap, 64);
    bad = 0;
    for (int i = 0; i < 64; i++) if (mem[i] !== 8'(i)) bad++;
    chk("nom_mem", bad, 0);
    boot_run(100, 100);
    #1;
    chk("nom_cc", a_cycle_count, 100);
    chk("nom_te", a_timeout_err, 0);
    dump_all(-1, 0);
    chk("nom_cc_hold", a_cycle_count, 100);
    cyc();

    // Backpressure on both streams
    snap = wr_cnt;
    begin_run();
    load_bytes(8'h80, 1'b1);
    chk("bp_wr_count", wr_cnt - snap, 64);
    bad = 0;
    for (int i = 0; i < 64; i++) if (mem[i] !== 8'h80 + 8'(i)) bad++;
    chk("bp_mem", bad, 0);
    boot_run(5, 5);
    snap = out_cnt;
    dump_all(10, 3);
    chk("bp_out_count", out_cnt - snap, 64);
    cyc();

    // Timeout
    begin_run();
    load_bytes(8'h10, 1'b0);
    boot_run(0, 4096);
    #1;
    chk("to_te", a_timeout_err, 1);
    chk("to_cc", a_cycle_count, 4096);
    chk("to_dump", a_out_valid, 1);
    dump_all(-1, 0);
    chk("to_te_hold", a_timeout_err, 1);
    cyc();

    // Done coincides with the timeout cycle
    begin_run();
    load_bytes(8'h20, 1'b0);
    boot_run(4096, 4096);
    #1;
    chk("co_te", a_timeout_err, 0);
    chk("co_cc", a_cycle_count, 4096);
    chk("co_dump", a_out_valid, 1);
    dump_all(-1, 0);
    cyc();

    // Start while running is ignored, then reset mid-RUN
    begin_run();
    load_bytes(8'h30, 1'b0);
    boot_run(0, 20);
    a_start = 1'b1;
    cyc();
    a_start = 1'b0;
    #1;
    chk("busy_start_run", a_core_reset, 0);
    chk("busy_start_cc", a_cycle_count, 21);
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    #1;
    chk("rrun_busy", a_busy, 0);
    chk("rrun_core_reset", a_core_reset, 1);
    chk("rrun_out_valid", a_out_valid, 0);
    chk("rrun_cc", a_cycle_count, 0);
    cyc();

    // Reset mid-DUMP
    begin_run();
    load_bytes(8'h40, 1'b0);
    boot_run(3, 3);
    a_out_ready = 1'b1;
    for (int i = 0; i < 5; i++) cyc();
    #1;
    chk("rdump_pre_valid", a_out_valid, 1);
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    a_out_ready = 1'b0;
    #1;
    chk("rdump_busy", a_busy, 0);
    chk("rdump_out_valid", a_out_valid, 0);
    chk("rdump_core_reset", a_core_reset, 1);
    chk("rdump_cc", a_cycle_count, 0);
    cyc();

    // Wrapping load addresses, zero-length dump
    snap = b_ov_cnt;
    b_start = 1'b1;
    cyc();
    b_start = 1'b0;
    for (int i = 0; i < 10; i++) begin
      b_in_valid = 1'b1;
      b_in_data = 8'(i);
      #1;
      chk("wrap_addr", b_mem_addr, (250 + i) % 256);
      chk("wrap_wr", b_mem_wr_en, 1);
      cyc();
    end
    b_in_valid = 1'b0;
    #1;
    chk("wrap_boot_sel", b_mem_sel, 0);
    cyc();
    b_core_done = 1'b1;
    #1;
    chk("wrap_run", b_core_reset, 0);
    cyc();
    b_core_done = 1'b0;
    #1;
    chk("nodump_busy", b_busy, 0);
    chk("nodump_cc", b_cycle_count, 1);
    chk("nodump_no_valid", b_ov_cnt - snap, 0);

    // Zero-length load, short timeout, wrapping dump
    c_start = 1'b1;
    cyc();
    c_start = 1'b0;
    #1;
    chk("noload_in_ready", c_in_ready, 0);
    chk("noload_boot_sel", c_mem_sel, 0);
    chk("noload_boot_rst", c_core_reset, 1);
    chk("noload_busy", c_busy, 1);
    cyc();
    for (int k = 0; k < 8; k++) cyc();
    #1;
    chk("c_te", c_timeout_err, 1);
    chk("c_cc", c_cycle_count, 8);
    chk("c_dump", c_out_valid, 1);
    c_out_ready = 1'b1;
    for (int j = 0; j < 4; j++) begin
      #1;
      chk("c_dump_addr", c_mem_addr, (254 + j) % 256);
      chk("c_dump_data", c_out_data, 8'((254 + j) % 256) ^ 8'h3C);
      chk("c_dump_last", c_out_last, j == 3);
      cyc();
    end
    c_out_ready = 1'b0;
    #1;
    chk("c_end_busy", c_busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/run_sequencer.md
Name: run_sequencer

Overview:
Run controller that sits directly upstream of the processor core. While the core is held in reset, it streams operand bytes into data memory. It then releases the core and waits for the core's done flag, with a timeout guard. Finally it holds the core in reset again and streams a result window out of data memory over a valid/ready interface. It owns the data-memory port whenever the core is not running.

Parameters:
AW, 8, data memory address width
LOAD_BASE, 0, first data-memory address written during load
LOAD_LEN, 64, number of bytes loaded (0 = skip load)
DUMP_BASE, 64, first data-memory address read during dump
DUMP_LEN, 64, number of bytes dumped (0 = skip dump)
TIMEOUT, 4096, maximum RUN cycles before forced abort
CW, 16, cycle counter width

Ports:
clk  in  1  system clock, all state updates on rising edge
reset  in  1  synchronous active-high reset
start  in  1  begin a run; sampled only in IDLE
in_valid  in  1  load byte valid
in_data  in  8  load byte
in_ready  out  1  load byte accepted when in_valid&in_ready
core_reset  out  1  reset to core (PC, reg file, flags)
core_done  in  1  core done flag (PC MSB set)
mem_sel  out  1  1 = sequencer drives data-memory port, 0 = core drives it
mem_wr_en  out  1  data-memory write enable (sequencer side)
mem_addr  out  AW  data-memory address (sequencer side)
mem_wdat  out  8  data-memory write data
mem_rdat  in  8  data-memory combinational read data
out_valid  out  1  result byte valid
out_data  out  8  result byte
out_last  out  1  marks final result byte
out_ready  in  1  result consumer ready
busy  out  1  high in every state except IDLE
timeout_err  out  1  sticky: last run hit TIMEOUT
cycle_count  out  CW  RUN cycles of last/current run

Behaviour:
- States: IDLE, LOAD, BOOT, RUN, DUMP.
- Reset (any state, mid-run included): state=IDLE, idx=0, core_reset=1, mem_sel=1, mem_wr_en=0, in_ready=0, out_valid=0, out_last=0, busy=0, timeout_err=0, cycle_count=0.
- IDLE:
  - core_reset=1, mem_sel=1, no writes.
  - On start=1: clear cycle_count, timeout_err and idx.
  - Next state is LOAD if LOAD_LEN>0, else BOOT.
  - start is ignored in all other states.
- LOAD:
  - in_ready=1 and core_reset=1.
  - On a handshake: mem_wr_en=1 in the same cycle (combinational from in_valid), mem_addr=(LOAD_BASE+idx) mod 2^AW, mem_wdat=in_data, idx++.
  - Without a handshake, mem_wr_en=0.
  - After the LOAD_LEN-th handshake: idx=0, next state BOOT.
- BOOT:
  - Exactly 1 cycle with core_reset=1 and mem_sel=0, so the core clears its PC with memory handed back.
  - Next state RUN.
- RUN:
  - core_reset=0, mem_sel=0.
  - cycle_count increments once per RUN cycle and saturates at 2^CW-1.
  - core_done=1 sampled → DUMP on the next edge.
  - If cycle_count==TIMEOUT-1 and core_done=0: set timeout_err, go to DUMP.
  - If done and timeout coincide, done wins and timeout_err stays 0.
- DUMP:
  - core_reset=1 (core halted; data memory has no reset, so contents are retained), mem_sel=1, mem_wr_en=0.
  - mem_addr=(DUMP_BASE+idx) mod 2^AW, out_data=mem_rdat, out_valid=1.
  - out_last=1 when idx==DUMP_LEN-1.
  - out_data/out_last stay stable while out_ready=0; idx++ on a handshake.
  - After the last handshake → IDLE.
  - If DUMP_LEN=0, RUN exits directly to IDLE.
- cycle_count and timeout_err hold their values in IDLE until the next start.
- Address arithmetic wraps modulo 2^AW; no error on wrap.

Test Plan:
- Nominal run: reset, start, 64 bytes 0x00..0x3F loaded at addresses 0..63 with in_valid held high; the core model asserts core_done after 100 RUN cycles → exactly one BOOT cycle, cycle_count=100, 64 output bytes from addresses 64..127 with out_last on byte 63, then IDLE with busy=0.
- Backpressure: in_valid toggling 1-0-1 in LOAD and out_ready low for 3 cycles mid-DUMP → no missed or duplicate writes, out_data stable while stalled, total output count 64.
- Timeout: core_done never asserted → DUMP entered after 4096 RUN cycles, timeout_err=1, cycle_count=4095 before increment (4096 reported), results still dumped.
- Done/timeout coincident: core_done=1 on the cycle cycle_count==4095 → timeout_err=0.
- Reset mid-RUN and mid-DUMP: reset pulse → IDLE next cycle, core_reset=1, out_valid=0, cycle_count=0; start while busy (e.g. in RUN) has no effect.
- Wrap/zero lengths: LOAD_BASE=250, LOAD_LEN=10 → writes to 250..255 then 0..3; LOAD_LEN=0 → IDLE→BOOT directly; DUMP_LEN=0 → RUN→IDLE with no out_valid.
